// File: rtl/calendar_counter.sv
// Calendar / time-of-day counter on the 1 Hz tick: sec..year carry chain with Gregorian leap
// years, weekday tracking, set-mode stepping, sanitised parallel load, daily alarm and year rollover.
module calendar_counter #(
  parameter int YEAR_W    = 10,
  parameter int YEAR_MAX  = 974,
  parameter int YEAR_BASE = 2000,
  parameter int WDAY_RST  = 6
) (
  input  logic              clk_1s,
  input  logic              rst_n,
  input  logic              run,
  input  logic [2:0]        field,
  input  logic              inc,
  input  logic              dec,
  input  logic              load,
  input  logic [5:0]        ld_sec,
  input  logic [5:0]        ld_min,
  input  logic [5:0]        ld_hour,
  input  logic [4:0]        ld_day,
  input  logic [3:0]        ld_month,
  input  logic [YEAR_W-1:0] ld_year,
  input  logic [2:0]        ld_wday,
  input  logic              alarm_en,
  input  logic [5:0]        alarm_hour,
  input  logic [5:0]        alarm_min,
  output logic [5:0]        sec,
  output logic [5:0]        min,
  output logic [5:0]        hour,
  output logic [4:0]        day,
  output logic [3:0]        month,
  output logic [YEAR_W-1:0] year,
  output logic [2:0]        wday,
  output logic              alarm_pulse,
  output logic              rollover
);

  // Calendar year needs headroom above YEAR_W for the base offset; never narrower than 12 bits.
  localparam int                YW2   = (YEAR_W + 2 > 12) ? YEAR_W + 2 : 12;
  localparam logic [YEAR_W-1:0] YMAX  = YEAR_W'(YEAR_MAX);
  localparam logic [YW2-1:0]    YBASE = YW2'(YEAR_BASE);

  function automatic logic [4:0] max_day_f(input logic [3:0] m, input logic [YEAR_W-1:0] y);
    logic [YW2-1:0] cy;
    logic           leap;
    cy   = YBASE + YW2'(y);
    leap = ((cy % YW2'(4)) == '0) &&
           (((cy % YW2'(100)) != '0) || ((cy % YW2'(400)) == '0));
    case (m)
      4'd2:                    max_day_f = leap ? 5'd29 : 5'd28;
      4'd4, 4'd6, 4'd9, 4'd11: max_day_f = 5'd30;
      default:                 max_day_f = 5'd31;
    endcase
  endfunction

  logic [4:0]        max_day;
  logic [5:0]        n_sec, n_min, n_hour;
  logic [4:0]        n_day, md_new, ld_md;
  logic [3:0]        n_month;
  logic [YEAR_W-1:0] n_year;
  logic [2:0]        n_wday, lvl;
  logic              n_alarm, n_roll;
  logic              step_up, step_dn, carry, borrow, day_wrap, yr_wrap;

  assign max_day = max_day_f(month, year);

  always_comb begin
    n_sec    = sec;
    n_min    = min;
    n_hour   = hour;
    n_day    = day;
    n_month  = month;
    n_year   = year;
    n_wday   = wday;
    md_new   = '0;
    ld_md    = '0;
    step_up  = 1'b0;
    step_dn  = 1'b0;
    carry    = 1'b0;
    borrow   = 1'b0;
    day_wrap = 1'b0;
    yr_wrap  = 1'b0;
    lvl      = field;

    if (run) begin
      step_up = 1'b1;
      lvl     = 3'd0;
    end else if (field <= 3'd5) begin
      step_up = inc && !dec;
      step_dn = dec && !inc;
    end

    // Up chain: the selected level injects the carry, lower levels stay untouched.
    carry = step_up && (lvl == 3'd0);
    if (carry) begin
      if (sec == 6'd59) n_sec = '0;
      else begin n_sec = sec + 6'd1; carry = 1'b0; end
    end
    carry = carry || (step_up && (lvl == 3'd1));
    if (carry) begin
      if (min == 6'd59) n_min = '0;
      else begin n_min = min + 6'd1; carry = 1'b0; end
    end
    carry = carry || (step_up && (lvl == 3'd2));
    if (carry) begin
      if (hour == 6'd23) n_hour = '0;
      else begin n_hour = hour + 6'd1; carry = 1'b0; end
    end
    carry = carry || (step_up && (lvl == 3'd3));
    if (carry) begin
      n_wday = (wday == 3'd6) ? 3'd0 : wday + 3'd1;
      if (day >= max_day) n_day = 5'd1;
      else begin n_day = day + 5'd1; carry = 1'b0; end
    end
    carry = carry || (step_up && (lvl == 3'd4));
    if (carry) begin
      if (month >= 4'd12) n_month = 4'd1;
      else begin n_month = month + 4'd1; carry = 1'b0; end
    end
    carry = carry || (step_up && (lvl == 3'd5));
    if (carry) begin
      if (year >= YMAX) begin n_year = '0; yr_wrap = 1'b1; end
      else n_year = year + YEAR_W'(1);
    end

    // Down chain: a day borrow resolves to the length of the month reached after the borrow.
    borrow = step_dn && (lvl == 3'd0);
    if (borrow) begin
      if (sec == 6'd0) n_sec = 6'd59;
      else begin n_sec = sec - 6'd1; borrow = 1'b0; end
    end
    borrow = borrow || (step_dn && (lvl == 3'd1));
    if (borrow) begin
      if (min == 6'd0) n_min = 6'd59;
      else begin n_min = min - 6'd1; borrow = 1'b0; end
    end
    borrow = borrow || (step_dn && (lvl == 3'd2));
    if (borrow) begin
      if (hour == 6'd0) n_hour = 6'd23;
      else begin n_hour = hour - 6'd1; borrow = 1'b0; end
    end
    borrow = borrow || (step_dn && (lvl == 3'd3));
    if (borrow) begin
      n_wday = (wday == 3'd0) ? 3'd6 : wday - 3'd1;
      if (day <= 5'd1) day_wrap = 1'b1;
      else begin n_day = day - 5'd1; borrow = 1'b0; end
    end
    borrow = borrow || (step_dn && (lvl == 3'd4));
    if (borrow) begin
      if (month <= 4'd1) n_month = 4'd12;
      else begin n_month = month - 4'd1; borrow = 1'b0; end
    end
    borrow = borrow || (step_dn && (lvl == 3'd5));
    if (borrow) begin
      if (year == '0) n_year = YMAX;
      else n_year = year - YEAR_W'(1);
    end

    md_new = max_day_f(n_month, n_year);
    if (day_wrap) n_day = md_new;
    if ((step_up || step_dn) && ((lvl == 3'd4) || (lvl == 3'd5)) && (n_day > md_new))
      n_day = md_new;

    if (load) begin
      n_sec   = (ld_sec > 6'd59) ? 6'd0 : ld_sec;
      n_min   = (ld_min > 6'd59) ? 6'd0 : ld_min;
      n_hour  = (ld_hour > 6'd23) ? 6'd0 : ld_hour;
      n_month = ((ld_month == 4'd0) || (ld_month > 4'd12)) ? 4'd1 : ld_month;
      n_year  = (ld_year > YMAX) ? '0 : ld_year;
      n_wday  = (ld_wday == 3'd7) ? 3'd0 : ld_wday;
      ld_md   = max_day_f(n_month, n_year);
      if (ld_day == 5'd0)     n_day = 5'd1;
      else if (ld_day > ld_md) n_day = ld_md;
      else                     n_day = ld_day;
    end

    n_alarm = run && !load && alarm_en && (n_hour == alarm_hour) &&
              (n_min == alarm_min) && (n_sec == 6'd0);
    n_roll  = run && !load && yr_wrap;
  end

  always_ff @(posedge clk_1s or negedge rst_n) begin
    if (!rst_n) begin
      sec         <= '0;
      min         <= '0;
      hour        <= '0;
      day         <= 5'd1;
      month       <= 4'd1;
      year        <= '0;
      wday        <= 3'(WDAY_RST);
      alarm_pulse <= 1'b0;
      rollover    <= 1'b0;
    end else begin
      sec         <= n_sec;
      min         <= n_min;
      hour        <= n_hour;
      day         <= n_day;
      month       <= n_month;
      year        <= n_year;
      wday        <= n_wday;
      alarm_pulse <= n_alarm;
      rollover    <= n_roll;
    end
  end

endmodule

// File: tb/tb_calendar_counter.sv
// Bench for calendar_counter: directed calendar corner cases plus random traffic against a
// reference model that works on seconds-of-day and calendar dates rather than a digit chain.
module tb_calendar_counter;
  localparam int YEAR_W    = 10;
  localparam int YEAR_MAX  = 974;
  localparam int YEAR_BASE = 2000;
  localparam int WDAY_RST  = 6;

  logic              clk_1s = 1'b0;
  logic              rst_n;
  logic              run, inc, dec, load, alarm_en;
  logic [2:0]        field, ld_wday;
  logic [5:0]        ld_sec, ld_min, ld_hour, alarm_hour, alarm_min;
  logic [4:0]        ld_day;
  logic [3:0]        ld_month;
  logic [YEAR_W-1:0] ld_year;
  logic [5:0]        sec, min, hour;
  logic [4:0]        day;
  logic [3:0]        month;
  logic [YEAR_W-1:0] year;
  logic [2:0]        wday;
  logic              alarm_pulse, rollover;

  int n_checks = 0;
  int n_errors = 0;
  int m_sec, m_min, m_hour, m_day, m_month, m_year, m_wday, m_alarm, m_roll, m_wrap;

  always #5 clk_1s = ~clk_1s;

  calendar_counter #(.YEAR_W(YEAR_W), .YEAR_MAX(YEAR_MAX), .YEAR_BASE(YEAR_BASE),
                     .WDAY_RST(WDAY_RST)) dut (
    .clk_1s(clk_1s), .rst_n(rst_n), .run(run), .field(field), .inc(inc), .dec(dec),
    .load(load), .ld_sec(ld_sec), .ld_min(ld_min), .ld_hour(ld_hour), .ld_day(ld_day),
    .ld_month(ld_month), .ld_year(ld_year), .ld_wday(ld_wday), .alarm_en(alarm_en),
    .alarm_hour(alarm_hour), .alarm_min(alarm_min), .sec(sec), .min(min), .hour(hour),
    .day(day), .month(month), .year(year), .wday(wday), .alarm_pulse(alarm_pulse),
    .rollover(rollover));

  task automatic check_val(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int dim(input int y, input int m);
    int cy;
    bit leap;
    cy   = YEAR_BASE + y;
    leap = (cy % 4 == 0) && ((cy % 100 != 0) || (cy % 400 == 0));
    if (m == 2) return leap ? 29 : 28;
    if (m == 4 || m == 6 || m == 9 || m == 11) return 30;
    return 31;
  endfunction

  task automatic next_day();
    m_wday = (m_wday + 1) % 7;
    m_day++;
    if (m_day > dim(m_year, m_month)) begin
      m_day = 1;
      m_month++;
      if (m_month > 12) begin
        m_month = 1;
        m_year++;
        if (m_year > YEAR_MAX) begin m_year = 0; m_wrap = 1; end
      end
    end
  endtask

  task automatic prev_day();
    m_wday = (m_wday + 6) % 7;
    m_day--;
    if (m_day < 1) begin
      m_month--;
      if (m_month < 1) begin
        m_month = 12;
        m_year--;
        if (m_year < 0) m_year = YEAR_MAX;
      end
      m_day = dim(m_year, m_month);
    end
  endtask

  task automatic shift_tod(input int delta);
    int tod;
    tod = m_hour * 3600 + m_min * 60 + m_sec + delta;
    if (tod >= 86400) begin tod -= 86400; next_day(); end
    if (tod < 0) begin tod += 86400; prev_day(); end
    m_hour = tod / 3600;
    m_min  = (tod / 60) % 60;
    m_sec  = tod % 60;
  endtask

  task automatic clamp_day();
    if (m_day > dim(m_year, m_month)) m_day = dim(m_year, m_month);
  endtask

  task automatic model_reset();
    m_sec = 0; m_min = 0; m_hour = 0; m_day = 1; m_month = 1; m_year = 0;
    m_wday = WDAY_RST; m_alarm = 0; m_roll = 0;
  endtask

  task automatic model_step();
    int d, idx, total;
    m_wrap = 0;
    d = inc ? 1 : -1;
    if (load) begin
      m_sec   = (ld_sec > 59) ? 0 : int'(ld_sec);
      m_min   = (ld_min > 59) ? 0 : int'(ld_min);
      m_hour  = (ld_hour > 23) ? 0 : int'(ld_hour);
      m_month = (ld_month == 0 || ld_month > 12) ? 1 : int'(ld_month);
      m_year  = (int'(ld_year) > YEAR_MAX) ? 0 : int'(ld_year);
      m_wday  = (ld_wday == 7) ? 0 : int'(ld_wday);
      m_day   = (ld_day == 0) ? 1 : int'(ld_day);
      clamp_day();
    end else if (run) begin
      shift_tod(1);
    end else if ((inc ^ dec) && field <= 5) begin
      case (field)
        3'd0: shift_tod(d);
        3'd1: shift_tod(60 * d);
        3'd2: shift_tod(3600 * d);
        3'd3: if (d > 0) next_day(); else prev_day();
        3'd4: begin
          total   = (YEAR_MAX + 1) * 12;
          idx     = (m_year * 12 + m_month - 1 + d + total) % total;
          m_year  = idx / 12;
          m_month = idx % 12 + 1;
          clamp_day();
        end
        default: begin
          m_year = (m_year + d + YEAR_MAX + 1) % (YEAR_MAX + 1);
          clamp_day();
        end
      endcase
    end
    m_alarm = int'(run && !load && alarm_en && m_hour == int'(alarm_hour) &&
                   m_min == int'(alarm_min) && m_sec == 0);
    m_roll  = int'(run && !load && m_wrap == 1);
  endtask

  task automatic check_all(input string ctx);
    check_val({ctx, ".sec"},   int'(sec),         m_sec);
    check_val({ctx, ".min"},   int'(min),         m_min);
    check_val({ctx, ".hour"},  int'(hour),        m_hour);
    check_val({ctx, ".day"},   int'(day),         m_day);
    check_val({ctx, ".month"}, int'(month),       m_month);
    check_val({ctx, ".year"},  int'(year),        m_year);
    check_val({ctx, ".wday"},  int'(wday),        m_wday);
    check_val({ctx, ".alarm"}, int'(alarm_pulse), m_alarm);
    check_val({ctx, ".roll"},  int'(rollover),    m_roll);
  endtask

  task automatic step(input string ctx);
    model_step();
    @(posedge clk_1s);
    #1;
    check_all(ctx);
  endtask

  task automatic op(input string ctx, input bit r, input int f, input bit i, input bit d);
    run = r; field = 3'(f); inc = i; dec = d; load = 1'b0;
    step(ctx);
    inc = 1'b0; dec = 1'b0;
  endtask

  task automatic do_load(input string ctx, input int y, input int mo, input int d,
                         input int h, input int mi, input int s, input int w);
    ld_year = YEAR_W'(y); ld_month = 4'(mo); ld_day = 5'(d);
    ld_hour = 6'(h); ld_min = 6'(mi); ld_sec = 6'(s); ld_wday = 3'(w);
    load = 1'b1; run = 1'b0; inc = 1'b0; dec = 1'b0;
    step(ctx);
    load = 1'b0;
  endtask

  task automatic rand_cycle();
    int r, ys;
    r = $urandom_range(0, 99);
    alarm_en = 1'($urandom_range(0, 1));
    if ($urandom_range(0, 15) == 0) begin
      alarm_hour = 6'(m_hour);
      alarm_min  = 6'((m_min + 1) % 60);
    end
    load = 1'b0; run = 1'b0; inc = 1'b0; dec = 1'b0;
    field = 3'($urandom_range(0, 7));
    if (r < 8) begin
      ys = $urandom_range(0, 5);
      case (ys)
        0: ld_year = '0;
        1: ld_year = YEAR_W'(YEAR_MAX);
        2: ld_year = YEAR_W'(($urandom_range(0, 1) == 0) ? 100 : 400);
        3: ld_year = YEAR_W'($urandom_range(0, (1 << YEAR_W) - 1));
        default: ld_year = YEAR_W'($urandom_range(0, YEAR_MAX));
      endcase
      if ($urandom_range(0, 1) == 0) begin
        ld_sec = 6'd59; ld_min = 6'd59; ld_hour = 6'd23;
        ld_day = 5'($urandom_range(28, 31));
        ld_month = ($urandom_range(0, 1) == 0) ? 4'd12 : 4'd2;
      end else begin
        ld_sec = 6'($urandom_range(0, 63)); ld_min = 6'($urandom_range(0, 63));
        ld_hour = 6'($urandom_range(0, 31)); ld_day = 5'($urandom_range(0, 31));
        ld_month = 4'($urandom_range(0, 15));
      end
      ld_wday = 3'($urandom_range(0, 7));
      load = 1'b1;
      run  = 1'($urandom_range(0, 1));
    end else if (r < 55) begin
      run = 1'b1;
      inc = 1'($urandom_range(0, 1));
    end else begin
      inc = 1'($urandom_range(0, 1));
      dec = 1'($urandom_range(0, 1));
    end
    step("rand");
  endtask

  initial begin
    rst_n = 1'b0; run = 1'b0; inc = 1'b0; dec = 1'b0; load = 1'b0; field = 3'd0;
    ld_sec = '0; ld_min = '0; ld_hour = '0; ld_day = '0; ld_month = '0; ld_year = '0;
    ld_wday = '0; alarm_en = 1'b0; alarm_hour = '0; alarm_min = '0;
    model_reset();
    #12;
    check_all("reset");
    rst_n = 1'b1;
    op("first_count", 1'b1, 0, 1'b0, 1'b0);
    check_val("first_count_sec", int'(sec), 1);

    do_load("ld_rollover", YEAR_MAX, 12, 31, 23, 59, 59, 2);
    op("rollover", 1'b1, 0, 1'b0, 1'b0);
    check_val("rollover_flag", int'(rollover), 1);
    check_val("rollover_wday", int'(wday), 3);
    op("rollover_clear", 1'b1, 0, 1'b0, 1'b0);
    check_val("rollover_clear_flag", int'(rollover), 0);

    do_load("ld_2024", 24, 2, 28, 23, 59, 59, 0);
    op("leap_2024", 1'b1, 0, 1'b0, 1'b0);
    check_val("leap_2024_day", int'(day), 29);
    do_load("ld_2100", 100, 2, 28, 23, 59, 59, 0);
    op("leap_2100", 1'b1, 0, 1'b0, 1'b0);
    check_val("leap_2100_month", int'(month), 3);
    do_load("ld_2400", 400, 2, 28, 23, 59, 59, 0);
    op("leap_2400", 1'b1, 0, 1'b0, 1'b0);
    check_val("leap_2400_day", int'(day), 29);

    do_load("ld_mar1", 24, 3, 1, 0, 0, 0, 4);
    op("dec_sec_borrow", 1'b0, 0, 1'b0, 1'b1);
    check_val("dec_borrow_day", int'(day), 29);
    check_val("dec_borrow_wday", int'(wday), 3);

    do_load("ld_jan31", 23, 1, 31, 12, 0, 0, 1);
    op("inc_month", 1'b0, 4, 1'b1, 1'b0);
    check_val("inc_month_clamp", int'(day), 28);
    op("dec_year", 1'b0, 5, 1'b0, 1'b1);
    op("inc_dec_hold", 1'b0, 2, 1'b1, 1'b1);
    op("field7_noop", 1'b0, 7, 1'b1, 1'b0);

    do_load("ld_sanitise", 5, 0, 31, 5, 10, 60, 7);
    check_val("sanitise_day", int'(day), 31);
    do_load("ld_apr31", 5, 4, 31, 5, 10, 0, 3);
    check_val("apr_clamp_day", int'(day), 30);
    ld_sec = 6'd7; ld_min = 6'd8; ld_hour = 6'd9; ld_day = 5'd10; ld_month = 4'd11;
    ld_year = YEAR_W'(12); ld_wday = 3'd5; load = 1'b1; run = 1'b1;
    step("load_plus_run");
    load = 1'b0;

    alarm_en = 1'b1; alarm_hour = 6'd7; alarm_min = 6'd30;
    do_load("ld_0729", 30, 6, 15, 7, 29, 59, 0);
    op("alarm_fire", 1'b1, 0, 1'b0, 1'b0);
    check_val("alarm_pulse_hi", int'(alarm_pulse), 1);
    op("alarm_after", 1'b1, 0, 1'b0, 1'b0);
    check_val("alarm_pulse_lo", int'(alarm_pulse), 0);
    do_load("alarm_by_load", 30, 6, 15, 7, 30, 0, 0);
    do_load("ld_0729b", 30, 6, 15, 7, 29, 59, 0);
    op("alarm_by_set", 1'b0, 0, 1'b1, 1'b0);
    check_val("alarm_set_quiet", int'(alarm_pulse), 0);

    ld_sec = 6'd30; ld_min = 6'd30; ld_hour = 6'd10; ld_day = 5'd5; ld_month = 4'd5;
    ld_year = YEAR_W'(50); ld_wday = 3'd2; load = 1'b1; run = 1'b0;
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all("async_reset");
    @(posedge clk_1s);
    #1;
    check_all("reset_holds");
    rst_n = 1'b1; load = 1'b0;
    op("post_reset_count", 1'b1, 0, 1'b0, 1'b0);

    for (int i = 0; i < 3000; i++) rand_cycle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
